ysyx_22050133_div: RTL and testbench

YSYX_22050133_DIV -- requirements
Module: ysyx_22050133_DIV

---
 rtl/ysyx_22050133_div.sv | 176 +++++++++++++++++
 tb/tb_ysyx_22050133_div.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050133_div.sv
// Multi-cycle restoring divider for RV64 DIV/DIVU/REM/REMU and their word forms.
// One quotient bit per clock. Divide-by-zero and signed overflow finish on the accepting edge.
module ysyx_22050133_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    input  logic        div_signed,
    input  logic        divw,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);

    localparam int unsigned XLEN  = 64;
    localparam int unsigned WLEN  = 32;
    localparam int unsigned CNT_W = 7;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   dvd_q, dvd_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              word_q, word_d;
    logic [XLEN-1:0]   quotient_q, quotient_d;
    logic [XLEN-1:0]   remainder_q, remainder_d;

    logic              accept;
    logic              sa, sb;
    logic [XLEN-1:0]   a_mag, b_mag, dvd_sext;
    logic [WLEN-1:0]   a_mag32, b_mag32;
    logic              by_zero, overflow;
    logic [XLEN:0]     shifted, diff;
    logic              q_bit;
    logic [XLEN-1:0]   rem_nx, quo_nx, q_fix, r_fix;

    assign accept = div_valid && (state_q == S_IDLE) && !flush;

    // Operand decode: operative signs, magnitudes and the two bypass conditions
    always_comb begin
        sa       = div_signed && (divw ? dividend[WLEN-1] : dividend[XLEN-1]);
        sb       = div_signed && (divw ? divisor[WLEN-1]  : divisor[XLEN-1]);
        a_mag32  = sa ? (~dividend[WLEN-1:0] + 32'd1) : dividend[WLEN-1:0];
        b_mag32  = sb ? (~divisor[WLEN-1:0]  + 32'd1) : divisor[WLEN-1:0];
        // Word dividends sit in the upper half so bits leave MSB-first like the 64-bit case
        a_mag    = divw ? {a_mag32, 32'd0}
                        : (sa ? (~dividend + 64'd1) : dividend);
        b_mag    = divw ? {32'd0, b_mag32}
                        : (sb ? (~divisor + 64'd1) : divisor);
        dvd_sext = divw ? {{WLEN{dividend[WLEN-1]}}, dividend[WLEN-1:0]} : dividend;
        by_zero  = divw ? (divisor[WLEN-1:0] == 32'd0) : (divisor == 64'd0);
        overflow = div_signed && (divw
                   ? (dividend[WLEN-1:0] == 32'h8000_0000 && divisor[WLEN-1:0] == 32'hFFFF_FFFF)
                   : (dividend == 64'h8000_0000_0000_0000 && divisor == 64'hFFFF_FFFF_FFFF_FFFF));
    end

    // One restoring step plus sign fix-up of its result
    always_comb begin
        shifted = {rem_q, dvd_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        q_bit   = !diff[XLEN];
        rem_nx  = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_nx  = {quo_q[XLEN-2:0], q_bit};
        q_fix   = q_neg_q ? (~quo_nx + 64'd1) : quo_nx;
        r_fix   = r_neg_q ? (~rem_nx + 64'd1) : rem_nx;
        if (word_q) begin
            q_fix = {{WLEN{q_fix[WLEN-1]}}, q_fix[WLEN-1:0]};
            r_fix = {{WLEN{r_fix[WLEN-1]}}, r_fix[WLEN-1:0]};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (by_zero || overflow) ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // Output decode
    always_comb begin
        div_ready = 1'b0;
        out_valid = 1'b0;
        if (state_q == S_IDLE) div_ready = 1'b1;
        if (state_q == S_DONE) out_valid = 1'b1;
    end

    // Datapath next values
    always_comb begin
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        word_d      = word_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        if (accept) begin
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            rem_d   = 64'd0;
            quo_d   = 64'd0;
            cnt_d   = divw ? CNT_W'(WLEN) : CNT_W'(XLEN);
            q_neg_d = sa ^ sb;
            r_neg_d = sa;
            word_d  = divw;
            if (by_zero) begin
                quotient_d  = 64'hFFFF_FFFF_FFFF_FFFF;
                remainder_d = dvd_sext;
            end else if (overflow) begin
                quotient_d  = dvd_sext;
                remainder_d = 64'd0;
            end
        end else if (state_q == S_CALC && !flush) begin
            dvd_d = {dvd_q[XLEN-2:0], 1'b0};
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                quotient_d  = q_fix;
                remainder_d = r_fix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            word_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            word_q      <= word_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_ysyx_22050133_div.sv
// Randomised bench for ysyx_22050133_div against an arithmetic RISC-V division model.
module tb_ysyx_22050133_div;

    logic        clk = 1'b0;
    logic        rst, flush, div_valid, div_signed, divw, out_ready;
    logic        div_ready, out_valid;
    logic [63:0] dividend, divisor, quotient, remainder;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_22050133_div dut (
        .clk(clk), .rst(rst), .flush(flush),
        .div_valid(div_valid), .div_ready(div_ready),
        .dividend(dividend), .divisor(divisor),
        .div_signed(div_signed), .divw(divw),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference: RISC-V M-extension results, with bypass latency 0 and N otherwise
    task automatic ref_div(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                           output logic [63:0] q, output logic [63:0] r, output int lat);
        logic [31:0] a32, b32, q32, r32;
        a32 = a[31:0];
        b32 = b[31:0];
        lat = w ? 32 : 64;
        if (w) begin
            if (b32 == 0) begin
                q = '1; r = sext32(a32); lat = 0;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q = sext32(a32); r = 0; lat = 0;
            end else begin
                if (s) begin
                    q32 = 32'($signed(a32) / $signed(b32));
                    r32 = 32'($signed(a32) % $signed(b32));
                end else begin
                    q32 = a32 / b32;
                    r32 = a32 % b32;
                end
                q = sext32(q32); r = sext32(r32);
            end
        end else begin
            if (b == 0) begin
                q = '1; r = a; lat = 0;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q = a; r = 0; lat = 0;
            end else if (s) begin
                q = 64'($signed(a) / $signed(b));
                r = 64'($signed(a) % $signed(b));
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endtask

    // Issue one request, scramble inputs after acceptance, wait for out_valid and check
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w,
                          input string tag, input bit release_result);
        logic [63:0] eq, er;
        int elat, lat;
        ref_div(a, b, s, w, eq, er, elat);
        @(negedge clk);
        dividend = a; divisor = b; div_signed = s; divw = w; div_valid = 1'b1;
        @(posedge clk); #1;
        div_valid = 1'b0;
        dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom};
        div_signed = 1'($urandom); divw = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'(elat));
        check({tag, ".q"}, quotient, eq);
        check({tag, ".r"}, remainder, er);
        if (release_result) begin
            @(negedge clk); out_ready = 1'b1;
            @(posedge clk); #1; out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] a, b, q_hold, r_hold;
        logic        s, w;
        bit          seen;
        rst = 1'b1; flush = 1'b0; div_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0; div_signed = 1'b0; divw = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready", 64'(div_ready), 64'd1);
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.q", quotient, 64'd0);
        check("rst.r", remainder, 64'd0);
        @(negedge clk); rst = 1'b0;

        run_op(64'd100, 64'd7, 1'b0, 1'b0, "divu", 1'b1);
        run_op(-64'sd7, 64'd2, 1'b1, 1'b0, "div_neg", 1'b1);
        run_op(64'h0000_0000_8000_0000, '1, 1'b1, 1'b1, "divw_ovf", 1'b1);
        run_op(64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 1'b1, "divuw_zero", 1'b1);
        run_op(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, "div_ovf", 1'b1);
        run_op(64'hDEAD_BEEF_0000_0005, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1, "divuw_hi0", 1'b1);

        // Backpressure: result and handshake outputs hold while out_ready is low
        run_op(64'd1000, 64'd33, 1'b0, 1'b0, "bp", 1'b0);
        q_hold = quotient; r_hold = remainder;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (quotient !== q_hold || remainder !== r_hold || !out_valid || div_ready) seen = 1'b1;
        end
        check("bp.stable", 64'(seen), 64'd0);
        @(negedge clk);
        out_ready = 1'b1; div_valid = 1'b1; dividend = 64'd50; divisor = 64'd5;
        div_signed = 1'b0; divw = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.idle_ready", 64'(div_ready), 64'd1);
        check("bp.idle_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        div_valid = 1'b0;
        check("bp.accepted", 64'(div_ready), 64'd0);
        repeat (64) @(posedge clk);
        #1;
        check("bp.q2", quotient, 64'd10);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;

        // Flush at iteration 20 abandons the operation
        @(negedge clk);
        dividend = 64'd999; divisor = 64'd3; div_signed = 1'b0; divw = 1'b0; div_valid = 1'b1;
        @(posedge clk); #1; div_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush.ready", 64'(div_ready), 64'd1);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("flush.no_valid", 64'(seen), 64'd0);

        // Reset while in DONE
        run_op(64'd77, 64'd5, 1'b0, 1'b0, "pre_rst", 1'b0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        check("rstdone.valid", 64'(out_valid), 64'd0);
        check("rstdone.ready", 64'(div_ready), 64'd1);
        check("rstdone.q", quotient, 64'd0);
        check("rstdone.r", remainder, 64'd0);

        // Random operations with corner-case injection
        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            s = 1'($urandom);
            w = 1'($urandom);
            case ($urandom_range(0, 5))
                1: b = 64'($urandom_range(1, 300));
                2: b = w ? {b[63:32], 32'd0} : 64'd0;
                3: begin s = 1'b1; b = '1;
                         a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000; end
                4: begin a = 64'($urandom_range(0, 5000)); b = 64'($urandom_range(1, 50)); end
                5: begin a = -64'($urandom_range(0, 5000)); b = -64'($urandom_range(1, 50)); end
                default: ;
            endcase
            run_op(a, b, s, w, $sformatf("rnd%0d", i), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
